// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: NOP encoding, queue entry layout, reset PC default.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package fetch_stage_pkg;

  localparam logic [`INSTR_WIDTH-1:0] NOP_INSTRUCTION  = 32'h0000_0013;
  localparam logic [`DATA_WIDTH-1:0]  RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [`DATA_WIDTH-1:0]  pc;
    logic [`INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush wins over push and pop.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         empty
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush && (count < (AW+1)'(DEPTH));
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request channel, instruction queue.
// Optional FETCH_MISALIGN_CHECK_EN adds sticky fetch_misalign_o on misaligned redirect targets.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [`DATA_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned            BUF_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_f_i,
  input  logic                    redirect_i,
  input  logic [`DATA_WIDTH-1:0]  redirect_pc_i,
  output logic                    imem_req_valid_o,
  input  logic                    imem_req_ready_i,
  output logic [`DATA_WIDTH-1:0]  imem_req_addr_o,
  input  logic                    imem_rsp_valid_i,
  input  logic [`INSTR_WIDTH-1:0] imem_rsp_data_i,
  output logic [`INSTR_WIDTH-1:0] instr_f_o,
  output logic [`DATA_WIDTH-1:0]  pc_f_o,
  output logic [`DATA_WIDTH-1:0]  pc_plus_4_f_o,
  output logic                    fetch_valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                    fetch_misalign_o
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  logic [`DATA_WIDTH-1:0] fetch_pc;
  logic [`DATA_WIDTH-1:0] inflight_pc;
  logic                   outstanding;
  logic                   discard;
  logic                   halt;
  logic [`DATA_WIDTH-1:0] redirect_tgt;
  logic                   pop;
  logic                   push;
  logic                   req_hs;
  logic [CW:0]            occupancy;
  logic [CW-1:0]          count;
  logic                   empty;
  fetch_entry_t           head;
  fetch_entry_t           push_entry;

  assign redirect_tgt = redirect_pc_i & ~`DATA_WIDTH'(3);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst)                                    misalign_q <= 1'b0;
    else if (redirect_i && |redirect_pc_i[1:0]) misalign_q <= 1'b1;
  end
  assign halt             = misalign_q;
  assign fetch_misalign_o = misalign_q;
`else
  assign halt = 1'b0;
`endif

  assign pop       = fetch_valid_o && !stall_f_i;
  // Entries already queued plus the one in flight, minus what leaves this cycle.
  assign occupancy = {1'b0, count} + (CW+1)'(outstanding) - (CW+1)'(pop);

  assign imem_req_valid_o = !rst && !redirect_i && !halt
                         && (!outstanding || imem_rsp_valid_i)
                         && (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr_o  = fetch_pc & ~`DATA_WIDTH'(3);
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;

  assign push       = imem_rsp_valid_i && outstanding && !discard && !redirect_i && !rst;
  assign push_entry = '{pc: inflight_pc, instr: imem_rsp_data_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc    <= redirect_tgt;
      outstanding <= outstanding && !imem_rsp_valid_i;
      if (outstanding && !imem_rsp_valid_i) discard <= 1'b1;
      else if (imem_rsp_valid_i)            discard <= 1'b0;
    end else begin
      if (req_hs) begin
        fetch_pc    <= fetch_pc + `DATA_WIDTH'(4);
        inflight_pc <= imem_req_addr_o;
        outstanding <= 1'b1;
      end else if (imem_rsp_valid_i) begin
        outstanding <= 1'b0;
      end
      if (imem_rsp_valid_i) discard <= 1'b0;
    end
  end

  fetch_queue #(.DEPTH(BUF_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_i || halt),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  assign fetch_valid_o = !empty;
  assign instr_f_o     = empty ? NOP_INSTRUCTION : head.instr;
  assign pc_f_o        = empty ? '0 : head.pc;
  assign pc_plus_4_f_o = empty ? '0 : head.pc + `DATA_WIDTH'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: behavioural imem with variable latency, expected-entry queue.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic [31:0] instr_f_o;
  logic [31:0] pc_f_o;
  logic [31:0] pc_plus_4_f_o;
  logic        fetch_valid_o;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_f_i        (stall_f_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .instr_f_o        (instr_f_o),
    .pc_f_o           (pc_f_o),
    .pc_plus_4_f_o    (pc_plus_4_f_o),
    .fetch_valid_o    (fetch_valid_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  // imem model state
  int          lat = 1;
  int          pcnt = 0;
  logic        pend = 1'b0, pend_wrong = 1'b0, rsp_wrong = 1'b0;
  logic [31:0] pend_pc, pend_dut_addr, rsp_pc;
  logic        hs_s = 1'b0, rst_s = 1'b1;
  logic [31:0] hs_pc_s, hs_addr_s;

  task automatic mem_drive();
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = mem_data(pend_dut_addr);
    rsp_pc           = pend_pc;
    rsp_wrong        = pend_wrong;
    pend             = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    imem_rsp_valid_i = 1'b0;
    if (rst_s) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (pcnt == 0) mem_drive();
        else pcnt--;
      end
      if (hs_s) begin
        pend          = 1'b1;
        pend_wrong    = 1'b0;
        pcnt          = lat - 1;
        pend_pc       = hs_pc_s;
        pend_dut_addr = hs_addr_s;
        if (pcnt == 0) mem_drive();
      end
    end
  end

  // scoreboard / reference model, sampled mid-cycle
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        exp_q[$];
  logic [31:0] exp_fpc = RST_PC;
  logic        infl = 1'b0;
  int          cyc = 0;

  always @(negedge clk) begin
    automatic logic hs, pop, exp_rv;
    automatic int   occ;
    hs     = imem_req_valid_o && imem_req_ready_i;
    pop    = fetch_valid_o && !stall_f_i && !redirect_i && !rst;
    occ    = exp_q.size() + int'(infl) - int'(fetch_valid_o && !stall_f_i);
    exp_rv = !rst && !redirect_i && (!infl || imem_rsp_valid_i) && (occ < 2);

    check_eq("req_valid", {31'b0, imem_req_valid_o}, {31'b0, exp_rv});
    check_eq("fetch_valid", {31'b0, fetch_valid_o}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check_eq("instr", instr_f_o, exp_q[0].instr);
      check_eq("pc", pc_f_o, exp_q[0].pc);
      check_eq("pc_plus_4", pc_plus_4_f_o, exp_q[0].pc + 32'd4);
    end else begin
      check_eq("instr_nop", instr_f_o, NOP_INSTRUCTION);
      check_eq("pc_empty", pc_f_o, 32'h0);
      check_eq("pc4_empty", pc_plus_4_f_o, 32'h0);
    end
    if (imem_req_valid_o) check_eq("req_addr", imem_req_addr_o, exp_fpc);
    if (!rst) begin
      if (cyc == 0) check_eq("first_req_hs", {31'b0, hs}, 32'd1);
      if (cyc == 1) check_eq("no_bypass", {31'b0, fetch_valid_o}, 32'd0);
      if (cyc == 2) check_eq("first_instr_valid", {31'b0, fetch_valid_o}, 32'd1);
    end

    hs_s      = hs;
    hs_pc_s   = exp_fpc;
    hs_addr_s = imem_req_addr_o;
    rst_s     = rst;
    if (rst) begin
      exp_q.delete();
      infl    = 1'b0;
      exp_fpc = RST_PC;
      cyc     = 0;
    end else begin
      cyc++;
      if (redirect_i) begin
        exp_q.delete();
        exp_fpc = redirect_pc_i;
        if (pend) pend_wrong = 1'b1;
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (imem_rsp_valid_i && !rsp_wrong) exp_q.push_back('{rsp_pc, mem_data(rsp_pc)});
        if (hs) exp_fpc = exp_fpc + 32'd4;
      end
      infl = hs ? 1'b1 : (imem_rsp_valid_i ? 1'b0 : infl);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_i    = 1'b1;
    redirect_pc_i = tgt;
    cycles(1);
    redirect_i    = 1'b0;
  endtask

  // Wait (bounded) until a request is in flight with no response yet.
  task automatic wait_pending(input string tag);
    automatic logic found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend) found = 1'b1;
      else cycles(1);
    end
    check_eq(tag, {31'b0, found}, 32'd1);
  endtask

  task automatic wait_response(input string tag);
    automatic logic found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_rsp_valid_i) found = 1'b1;
      else cycles(1);
    end
    check_eq(tag, {31'b0, found}, 32'd1);
  endtask

  initial begin
    rst              = 1'b1;
    stall_f_i        = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;

    cycles(3);
    rst = 1'b0;
    cycles(10);

    stall_f_i = 1'b1;
    cycles(5);
    stall_f_i = 1'b0;
    cycles(6);

    lat = 3;
    cycles(2);
    wait_pending("inflight_wait_a");
    do_redirect(32'h0000_0100);
    cycles(12);

    lat = 1;
    cycles(3);
    wait_response("rsp_wait");
    do_redirect(32'h0000_0200);
    cycles(4);

    imem_req_ready_i = 1'b0;
    cycles(4);
    imem_req_ready_i = 1'b1;
    cycles(4);

    do_redirect(32'hFFFF_FFF8);
    cycles(8);

    stall_f_i = 1'b1;
    cycles(3);
    do_redirect(32'h0000_0040);
    cycles(3);
    stall_f_i = 1'b0;
    cycles(6);

    lat = 3;
    cycles(1);
    wait_pending("inflight_wait_b");
    rst = 1'b1;
    cycles(1);
    lat = 1;
    rst = 1'b0;
    cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage. Owns the PC, issues word fetches to instruction memory over a valid/ready request channel, and buffers returned instructions in a small queue. Drives the fetch-side inputs of the IF/ID pipeline register: instruction, PC and PC+4. Supplies a NOP bubble whenever no fetched instruction is ready, and discards wrong-path fetches on a redirect from Execute.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- BUF_DEPTH, 2: instruction queue entries; power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high. One clock domain.
- stall_f_i  in  1  hazard unit stall; hold the queue head, no pop.
- redirect_i  in  1  taken branch or jump from Execute.
- redirect_pc_i  in  `DATA_WIDTH  redirect target.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts the request.
- imem_req_addr_o  out  `DATA_WIDTH  word address; bits [1:0] are always 0.
- imem_rsp_valid_i  in  1  response valid; no back-pressure.
- imem_rsp_data_i  in  `INSTR_WIDTH  fetched instruction.
- instr_f_o  out  `INSTR_WIDTH  queue head instruction, or 32'h0000_0013 when empty.
- pc_f_o  out  `DATA_WIDTH  head PC, or 0 when empty.
- pc_plus_4_f_o  out  `DATA_WIDTH  head PC + 4, or 0 when empty.
- fetch_valid_o  out  1  queue non-empty.

## Operation
- Registers:
  - fetch_pc: next address to request.
  - outstanding (0/1): at most one request is in flight.
  - discard (0/1): the next response is dropped.
  - queue: entries of {pc, instr}, with count.
- Request rule: imem_req_valid_o = !rst && !redirect_i && (outstanding==0 || imem_rsp_valid_i) && (count + outstanding − pop) < BUF_DEPTH.
  - The memory must not assume valid stays high before ready.
- Request handshake: fetch_pc += 4 (mod 2^32). Set outstanding = 1 and record the request PC in the in-flight PC register.
- Response handling:
  - discard=0: push {in-flight PC, data}.
  - discard=1: drop the response and clear discard.
  - In both cases outstanding clears, unless a new handshake occurs in the same cycle.
- Pop: when fetch_valid_o && !stall_f_i. The IF/ID register captures the head on the same edge.
- Redirect (priority over stall, response and pop):
  - Flush the queue (count = 0) and set fetch_pc = redirect_pc_i.
  - If a request is outstanding and its response is not present this cycle, set discard = 1.
  - No request is issued in the redirect cycle.
- Response arriving in the same cycle as a redirect: dropped.
- Simultaneous push and pop: count unchanged. A push into an empty queue appears on the outputs the next cycle; there is no bypass.
- pc_plus_4_f_o is pc + 4 with 32-bit wrap; 32'hFFFF_FFFC yields 0.
- Reset (any cycle, including with a request outstanding):
  - count = 0, outstanding = 0, discard = 0, fetch_pc = RESET_PC.
  - Outputs go to NOP / 0 / 0 / 0; imem_req_valid_o = 0.
  - A response arriving while rst is high is ignored. The memory is reset alongside this block.

## Timing
- First request: the cycle after rst deasserts, with addr = RESET_PC.
- Memory latency ≥1 cycle after the handshake. The instruction is visible on instr_f_o the cycle after its response.
- With 1-cycle memory and no stalls: one instruction per cycle, starting 2 cycles after the first request.
- Redirect at edge t: first request to the target at t+1. The earliest target instruction appears at t+3 with 1-cycle memory.
- All outputs come from registers, except imem_req_valid_o, which is combinational on redirect_i, imem_rsp_valid_i and stall_f_i.

## Configuration
- FETCH_MISALIGN_CHECK_EN:
  - Defined: redirect_pc_i[1:0] != 0 sets sticky output fetch_misalign_o and stops issuing requests. The queue is flushed and NOP bubbles are emitted. Only rst clears it.
  - Undefined: the port is absent and redirect_pc_i[1:0] are forced to 0.

## Structure
- Shared package: NOP_INSTRUCTION, the fetch entry struct {pc, instr}, and the RESET_PC default.
- One sub-module, fetch_queue: synchronous FIFO with push, pop, flush, count, and head outputs. Flush has priority over push.

## Test plan
- Reset, 1-cycle always-ready memory returning addr-derived data: requests at 0, 4, 8… one per cycle; instr_f_o valid from the 3rd cycle after reset; pc_plus_4 = pc + 4.
- stall_f_i held 5 cycles: head is held, at most BUF_DEPTH entries are queued, and requests stop once count + outstanding = 2; no instruction is lost or duplicated after release.
- Redirect to 0x100 while a request to 0x8 is in flight (3-cycle latency): the 0x8 response is dropped, and the next valid output has pc = 0x100.
- Redirect in the same cycle as a response: the response is dropped, the queue is empty next cycle, and the outputs show NOP/0.
- imem_req_ready_i low for 4 cycles: fetch_pc and addr are held, and NOP bubbles are emitted with fetch_valid_o = 0.
- rst asserted with a request outstanding: all outputs return to their reset values the next cycle, and the first request after rst deasserts is to RESET_PC.
